// File: rtl/label_fusion_voter.sv
// Fuses audio/video classifier results by minimum Hamming distance, then smooths the fused
// label with a majority vote over a WINDOW-deep history. Optional macro: FUSION_CONFIDENCE_EN.
module label_fusion_voter #(
  parameter int CLASSES        = 5,
  parameter int LABEL_WIDTH    = 3,
  parameter int DISTANCE_WIDTH = 10,
  parameter int WINDOW         = 5
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RBI,
  input  logic                      ValidIn_SI,
  output logic                      ReadyOut_SO,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_A_DI,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_V_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_V_DI,
  input  logic                      Clear_SI,
  output logic                      ValidOut_SO,
  input  logic                      ReadyIn_SI,
  output logic [LABEL_WIDTH-1:0]    FusedLabel_DO,
  output logic [DISTANCE_WIDTH-1:0] FusedDistance_DO,
  output logic [LABEL_WIDTH-1:0]    VotedLabel_DO,
  output logic [3:0]                VoteCount_DO
`ifdef FUSION_CONFIDENCE_EN
  ,
  output logic [DISTANCE_WIDTH-1:0] ConfidenceOut_DO
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FUSE   = 2'd1,
    VOTE   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // History is sized to the full 4-bit pointer range so pointer indexing is width-exact.
  localparam int HIST_DEPTH = 16;
  localparam logic [LABEL_WIDTH-1:0] LAST_CLASS = LABEL_WIDTH'(CLASSES - 1);
  localparam logic [3:0] WINDOW_W = 4'(WINDOW);
  localparam logic [3:0] LAST_PTR = 4'(WINDOW - 1);

  state_t                    state_r;
  logic [LABEL_WIDTH-1:0]    aLabel_r, vLabel_r;
  logic [DISTANCE_WIDTH-1:0] aDist_r, vDist_r;
  logic [LABEL_WIDTH-1:0]    hist_r [HIST_DEPTH];
  logic [3:0]                wPtr_r, fill_r;
  logic [LABEL_WIDTH-1:0]    curLabel_r, bestLabel_r, classCnt_r;
  logic [DISTANCE_WIDTH-1:0] curDist_r;
  logic [3:0]                bestCount_r;
  logic [LABEL_WIDTH-1:0]    fusedLabel_r, votedLabel_r;
  logic [DISTANCE_WIDTH-1:0] fusedDist_r;
  logic [3:0]                voteCount_r;
  logic [DISTANCE_WIDTH-1:0] curConf_r, conf_r;

  logic [LABEL_WIDTH-1:0]    fuseLabel_s, finalLabel_s;
  logic [DISTANCE_WIDTH-1:0] fuseDist_s, fuseConf_s;
  logic [3:0]                fuseCount_s, classCount_s, finalCount_s;

  assign ReadyOut_SO      = (state_r == IDLE);
  assign ValidOut_SO      = (state_r == OUTPUT);
  assign FusedLabel_DO    = fusedLabel_r;
  assign FusedDistance_DO = fusedDist_r;
  assign VotedLabel_DO    = votedLabel_r;
  assign VoteCount_DO     = voteCount_r;
`ifdef FUSION_CONFIDENCE_EN
  assign ConfidenceOut_DO = conf_r;
`endif

  // Fusion decision: video wins only on a strictly smaller distance.
  always_comb begin
    fuseLabel_s = aLabel_r;
    fuseDist_s  = aDist_r;
    fuseConf_s  = {DISTANCE_WIDTH{1'b0}};
    if (vDist_r < aDist_r) begin
      fuseLabel_s = vLabel_r;
      fuseDist_s  = vDist_r;
      fuseConf_s  = aDist_r - vDist_r;
    end else begin
      fuseLabel_s = aLabel_r;
      fuseDist_s  = aDist_r;
      fuseConf_s  = vDist_r - aDist_r;
    end
  end

  // Occurrence counts: the fused label's count skips the slot it is about to overwrite.
  always_comb begin
    fuseCount_s  = 4'd1;
    classCount_s = 4'd0;
    for (int i = 0; i < WINDOW; i++) begin
      if ((4'(i) < fill_r) && (4'(i) != wPtr_r) && (hist_r[i] == fuseLabel_s)) begin
        fuseCount_s = fuseCount_s + 4'd1;
      end else begin
        fuseCount_s = fuseCount_s;
      end
      if ((4'(i) < fill_r) && (hist_r[i] == classCnt_r)) begin
        classCount_s = classCount_s + 4'd1;
      end else begin
        classCount_s = classCount_s;
      end
    end
  end

  // Strictly-greater replacement keeps ties on the fused label or the lowest class.
  always_comb begin
    finalLabel_s = bestLabel_r;
    finalCount_s = bestCount_r;
    if (classCount_s > bestCount_r) begin
      finalLabel_s = classCnt_r;
      finalCount_s = classCount_s;
    end else begin
      finalLabel_s = bestLabel_r;
      finalCount_s = bestCount_r;
    end
  end

  // Control FSM, history and output registers.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      state_r      <= IDLE;
      aLabel_r     <= {LABEL_WIDTH{1'b0}};
      vLabel_r     <= {LABEL_WIDTH{1'b0}};
      aDist_r      <= {DISTANCE_WIDTH{1'b0}};
      vDist_r      <= {DISTANCE_WIDTH{1'b0}};
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_r[i] <= {LABEL_WIDTH{1'b0}};
      end
      wPtr_r       <= 4'd0;
      fill_r       <= 4'd0;
      curLabel_r   <= {LABEL_WIDTH{1'b0}};
      curDist_r    <= {DISTANCE_WIDTH{1'b0}};
      curConf_r    <= {DISTANCE_WIDTH{1'b0}};
      bestLabel_r  <= {LABEL_WIDTH{1'b0}};
      bestCount_r  <= 4'd0;
      classCnt_r   <= {LABEL_WIDTH{1'b0}};
      fusedLabel_r <= {LABEL_WIDTH{1'b0}};
      fusedDist_r  <= {DISTANCE_WIDTH{1'b0}};
      votedLabel_r <= {LABEL_WIDTH{1'b0}};
      voteCount_r  <= 4'd0;
      conf_r       <= {DISTANCE_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (ValidIn_SI) begin
            aLabel_r <= LabelIn_A_DI;
            vLabel_r <= LabelIn_V_DI;
            aDist_r  <= DistanceIn_A_DI;
            vDist_r  <= DistanceIn_V_DI;
            state_r  <= FUSE;
          end else if (Clear_SI) begin
            wPtr_r <= 4'd0;
            fill_r <= 4'd0;
          end
        end
        FUSE: begin
          hist_r[wPtr_r] <= fuseLabel_s;
          wPtr_r         <= (wPtr_r == LAST_PTR) ? 4'd0 : wPtr_r + 4'd1;
          if (fill_r != WINDOW_W) begin
            fill_r <= fill_r + 4'd1;
          end
          curLabel_r  <= fuseLabel_s;
          curDist_r   <= fuseDist_s;
          curConf_r   <= fuseConf_s;
          bestLabel_r <= fuseLabel_s;
          bestCount_r <= fuseCount_s;
          classCnt_r  <= {LABEL_WIDTH{1'b0}};
          state_r     <= VOTE;
        end
        VOTE: begin
          bestLabel_r <= finalLabel_s;
          bestCount_r <= finalCount_s;
          if (classCnt_r == LAST_CLASS) begin
            fusedLabel_r <= curLabel_r;
            fusedDist_r  <= curDist_r;
            votedLabel_r <= finalLabel_s;
            voteCount_r  <= finalCount_s;
            conf_r       <= curConf_r;
            state_r      <= OUTPUT;
          end else begin
            classCnt_r <= classCnt_r + {{(LABEL_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        OUTPUT: begin
          if (ReadyIn_SI) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_label_fusion_voter.sv
// Directed self-checking bench for label_fusion_voter: fusion, sliding-window vote,
// handshake hold, clear and mid-vote reset. Honours FUSION_CONFIDENCE_EN when defined.
module tb_label_fusion_voter;

  localparam int CLASSES = 5;

  logic       Clk_CI = 1'b0;
  logic       Reset_RBI = 1'b0;
  logic       ValidIn_SI = 1'b0;
  logic       ReadyOut_SO;
  logic [2:0] LabelIn_A_DI = 3'd0;
  logic [2:0] LabelIn_V_DI = 3'd0;
  logic [9:0] DistanceIn_A_DI = 10'd0;
  logic [9:0] DistanceIn_V_DI = 10'd0;
  logic       Clear_SI = 1'b0;
  logic       ValidOut_SO;
  logic       ReadyIn_SI = 1'b0;
  logic [2:0] FusedLabel_DO;
  logic [9:0] FusedDistance_DO;
  logic [2:0] VotedLabel_DO;
  logic [3:0] VoteCount_DO;
`ifdef FUSION_CONFIDENCE_EN
  logic [9:0] ConfidenceOut_DO;
`endif

  int nTests = 0;
  int nFail  = 0;

  label_fusion_voter dut (
    .Clk_CI          (Clk_CI),
    .Reset_RBI       (Reset_RBI),
    .ValidIn_SI      (ValidIn_SI),
    .ReadyOut_SO     (ReadyOut_SO),
    .LabelIn_A_DI    (LabelIn_A_DI),
    .LabelIn_V_DI    (LabelIn_V_DI),
    .DistanceIn_A_DI (DistanceIn_A_DI),
    .DistanceIn_V_DI (DistanceIn_V_DI),
    .Clear_SI        (Clear_SI),
    .ValidOut_SO     (ValidOut_SO),
    .ReadyIn_SI      (ReadyIn_SI),
    .FusedLabel_DO   (FusedLabel_DO),
    .FusedDistance_DO(FusedDistance_DO),
    .VotedLabel_DO   (VotedLabel_DO),
    .VoteCount_DO    (VoteCount_DO)
`ifdef FUSION_CONFIDENCE_EN
    ,
    .ConfidenceOut_DO(ConfidenceOut_DO)
`endif
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic checkVal(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkVal({tag, "_valid"}, int'(ValidOut_SO), 0);
    checkVal({tag, "_ready"}, int'(ReadyOut_SO), 1);
    checkVal({tag, "_fused"}, int'(FusedLabel_DO), 0);
    checkVal({tag, "_fdist"}, int'(FusedDistance_DO), 0);
    checkVal({tag, "_voted"}, int'(VotedLabel_DO), 0);
    checkVal({tag, "_count"}, int'(VoteCount_DO), 0);
`ifdef FUSION_CONFIDENCE_EN
    checkVal({tag, "_conf"}, int'(ConfidenceOut_DO), 0);
`endif
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (!ReadyOut_SO && k < 50) begin
      @(posedge Clk_CI); #1;
      k++;
    end
    checkVal({tag, "_idle"}, int'(ReadyOut_SO), 1);
  endtask

  // Accept one result, check it CLASSES+2 edges later, optionally stall, then release.
  task automatic runOne(input string tag, input int aL, input int aD, input int vL, input int vD,
                        input int eF, input int eD, input int eV, input int eC, input int hold);
    waitIdle(tag);
    LabelIn_A_DI    = 3'(aL);
    DistanceIn_A_DI = 10'(aD);
    LabelIn_V_DI    = 3'(vL);
    DistanceIn_V_DI = 10'(vD);
    ValidIn_SI      = 1'b1;
    @(posedge Clk_CI); #1;
    ValidIn_SI = 1'b0;
    repeat (CLASSES + 2) @(posedge Clk_CI);
    #1;
    checkVal({tag, "_valid"}, int'(ValidOut_SO), 1);
    checkVal({tag, "_rdyout"}, int'(ReadyOut_SO), 0);
    checkVal({tag, "_fused"}, int'(FusedLabel_DO), eF);
    checkVal({tag, "_fdist"}, int'(FusedDistance_DO), eD);
    checkVal({tag, "_voted"}, int'(VotedLabel_DO), eV);
    checkVal({tag, "_count"}, int'(VoteCount_DO), eC);
`ifdef FUSION_CONFIDENCE_EN
    checkVal({tag, "_conf"}, int'(ConfidenceOut_DO), (aD > vD) ? aD - vD : vD - aD);
`endif
    if (hold > 0) begin
      LabelIn_A_DI    = 3'd4;
      DistanceIn_A_DI = 10'd1;
      LabelIn_V_DI    = 3'd0;
      DistanceIn_V_DI = 10'd2;
      ValidIn_SI      = 1'b1;
      for (int c = 0; c < hold; c++) begin
        @(posedge Clk_CI); #1;
        checkVal({tag, "_hvalid"}, int'(ValidOut_SO), 1);
        checkVal({tag, "_hready"}, int'(ReadyOut_SO), 0);
        checkVal({tag, "_hfused"}, int'(FusedLabel_DO), eF);
        checkVal({tag, "_hvoted"}, int'(VotedLabel_DO), eV);
      end
      ValidIn_SI = 1'b0;
    end
    ReadyIn_SI = 1'b1;
    @(posedge Clk_CI); #1;
    ReadyIn_SI = 1'b0;
    checkVal({tag, "_released"}, int'(ValidOut_SO), 0);
    checkVal({tag, "_backidle"}, int'(ReadyOut_SO), 1);
    if (hold > 0) begin
      repeat (CLASSES + 4) @(posedge Clk_CI);
      #1;
      checkVal({tag, "_noextra"}, int'(ValidOut_SO), 0);
    end
  endtask

  task automatic clearHistory();
    waitIdle("clear");
    Clear_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Clear_SI = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk_CI);
    #1;
    checkZeroOutputs("reset");
    Reset_RBI = 1'b1;

    // Basic fusion: A closer, then equal distances favour A.
    runOne("t1", 2, 100, 3, 150, 2, 100, 2, 1, 0);
    runOne("t2", 1, 120, 4, 120, 1, 120, 1, 1, 0);

    // Fused 3,3,1,1,2,1: sixth result evicts the first 3.
    clearHistory();
    runOne("t3a", 3, 10, 0, 20, 3, 10, 3, 1, 0);
    runOne("t3b", 5, 30, 3, 7, 3, 7, 3, 2, 0);
    runOne("t3c", 1, 0, 1, 0, 1, 0, 3, 2, 0);
    runOne("t3d", 6, 1023, 1, 0, 1, 0, 1, 2, 0);
    runOne("t3e", 2, 512, 2, 600, 2, 512, 1, 2, 0);
    runOne("t3f", 1, 1022, 7, 1023, 1, 1022, 1, 3, 0);

    // Fused 2,2,4,4,0: tie goes to fused label 4, then to lowest class 2.
    clearHistory();
    runOne("t4a", 2, 4, 0, 9, 2, 4, 2, 1, 0);
    runOne("t4b", 7, 9, 2, 8, 2, 8, 2, 2, 0);
    runOne("t4c", 4, 1, 3, 2, 4, 1, 2, 2, 0);
    runOne("t4d", 4, 3, 4, 3, 4, 3, 4, 2, 0);
    runOne("t4e", 0, 6, 3, 6, 0, 6, 2, 2, 0);

    // Out-of-range labels win only as the fused label.
    clearHistory();
    runOne("oor1", 6, 1, 0, 2, 6, 1, 6, 1, 0);
    runOne("oor2", 6, 4, 6, 9, 6, 4, 6, 2, 0);
    runOne("oor3", 0, 3, 6, 5, 0, 3, 0, 1, 0);

    // Downstream stall with upstream still offering data.
    clearHistory();
    runOne("hold", 3, 40, 2, 50, 3, 40, 3, 1, 10);

    // Reset while voting, then a fresh single result.
    waitIdle("rst");
    LabelIn_A_DI    = 3'd2;
    DistanceIn_A_DI = 10'd11;
    LabelIn_V_DI    = 3'd1;
    DistanceIn_V_DI = 10'd30;
    ValidIn_SI      = 1'b1;
    @(posedge Clk_CI); #1;
    ValidIn_SI = 1'b0;
    repeat (3) @(posedge Clk_CI);
    #1;
    Reset_RBI = 1'b0;
    @(posedge Clk_CI); #1;
    checkZeroOutputs("midreset");
    Reset_RBI = 1'b1;
    runOne("t6a", 0, 5, 1, 9, 0, 5, 0, 1, 0);

    // Clear in IDLE discards the 3,3 history.
    clearHistory();
    runOne("t6b", 3, 2, 0, 8, 3, 2, 3, 1, 0);
    runOne("t6c", 3, 2, 0, 8, 3, 2, 3, 2, 0);
    clearHistory();
    runOne("t6d", 4, 9, 1, 3, 1, 3, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
